rand_bounded: RTL and testbench

- Sits directly downstream of the 16-bit LFSR. Drives the LFSR's advance strobe and consumes its 16-bit state.
- Produces uniformly distributed values in [0, RANGE) using rejection sampling. Game logic uses these for obstacle heights and spawn delays.
- Results are delivered through a valid/ready handshake. A bounded retry count guarantees a deterministic worst-case latency.

---
 rtl/rand_bounded.sv | 138 +++++++++++++
 tb/tb_rand_bounded.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rand_bounded.sv
// rand_bounded
// Turns the raw 16-bit LFSR state into uniformly distributed values in
// [0, RANGE) using rejection sampling. After MAX_TRIES samples, the result is
// forced by folding the last candidate back into range. This bounds the
// worst-case latency.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   rand_i        current LFSR state (16 bits)
//   lfsr_next_o   advance strobe to the LFSR (high while sampling)
//   value_o       bounded result, stable while valid_o is high
//   valid_o       value_o holds an unconsumed result
//   ready_i       consumer accepts value_o
//   reject_cnt_o  saturating count of rejected samples since reset
module rand_bounded #(
  parameter int OUT_W     = 8,
  parameter int RANGE     = 100,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      rand_i,
  output logic             lfsr_next_o,
  output logic [OUT_W-1:0] value_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [15:0]      reject_cnt_o
);

  // Candidate width. It is just wide enough to cover RANGE, so that
  // 2**MASK_W < 2*RANGE. This is why a single subtraction always folds a
  // rejected candidate into range.
  localparam int MASK_W = (RANGE <= 1) ? 1 : $clog2(RANGE);
  localparam int TRY_W  = (MAX_TRIES <= 1) ? 1 : $clog2(MAX_TRIES);

  localparam logic [16:0]      RANGE_EXT = 17'(RANGE);
  localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    WARM   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [TRY_W-1:0]   try_reg, try_next;
  logic [OUT_W-1:0]   value_reg, value_next;
  logic               valid_reg, valid_next;
  logic [15:0]        rej_reg, rej_next;

  logic [16:0]        cand_ext;
  logic               cand_ok;

  // Only the low MASK_W bits of the LFSR state are used as the candidate.
  assign cand_ext = {{(17 - MASK_W){1'b0}}, rand_i[MASK_W-1:0]};
  assign cand_ok  = (cand_ext < RANGE_EXT);

  generate
    if (MASK_W < 16) begin : g_unused
      logic unused_rand_bits;
      assign unused_rand_bits = ^rand_i[15:MASK_W];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= WARM;
      try_reg   <= '0;
      value_reg <= '0;
      valid_reg <= 1'b0;
      rej_reg   <= '0;
    end else begin
      state_reg <= state_next;
      try_reg   <= try_next;
      value_reg <= value_next;
      valid_reg <= valid_next;
      rej_reg   <= rej_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    try_next   = try_reg;
    value_next = value_reg;
    valid_next = valid_reg;
    rej_next   = rej_reg;

    case (state_reg)
      // A single idle cycle. This lets the LFSR leave its own reset before
      // the first strobe is issued.
      WARM: begin
        state_next = SAMPLE;
      end

      SAMPLE: begin
        if (cand_ok) begin
          value_next = OUT_W'(cand_ext);
          valid_next = 1'b1;
          try_next   = '0;
          state_next = HOLD;
        end else begin
          if (rej_reg != 16'hFFFF) begin
            rej_next = rej_reg + 16'd1;
          end
          if (try_reg == LAST_TRY) begin
            // Out of retries: fold the candidate back into range.
            value_next = OUT_W'(cand_ext - RANGE_EXT);
            valid_next = 1'b1;
            try_next   = '0;
            state_next = HOLD;
          end else begin
            try_next = try_reg + TRY_W'(1);
          end
        end
      end

      HOLD: begin
        if (valid_reg && ready_i) begin
          valid_next = 1'b0;
          state_next = SAMPLE;
        end
      end

      default: begin
        state_next = WARM;
      end
    endcase
  end

  // All outputs are decoded from registers only. There is no path from
  // ready_i to any output.
  assign lfsr_next_o  = (state_reg == SAMPLE);
  assign value_o      = value_reg;
  assign valid_o      = valid_reg;
  assign reject_cnt_o = rej_reg;

endmodule

// File: tb/tb_rand_bounded.sv
module tb_rand_bounded;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] rand_i;
  logic        lfsr_next_o;
  logic [7:0]  value_o;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] reject_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus source: either a directed value or a maximal-length 16-bit
  // Galois LFSR that steps on the DUT's strobe.
  logic [15:0] rand_drv;
  logic        use_lfsr;
  logic [15:0] lfsr_q;

  assign rand_i = use_lfsr ? lfsr_q : rand_drv;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (use_lfsr && lfsr_next_o)
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  rand_bounded #(.OUT_W(8), .RANGE(100), .MAX_TRIES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rand_i       (rand_i),
    .lfsr_next_o  (lfsr_next_o),
    .value_o      (value_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .reject_cnt_o (reject_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  bit seen [100];
  int transfers;
  int cycles;
  int missing;

  initial begin
    rst_i    = 1'b1;
    ready_i  = 1'b0;
    rand_drv = 16'h0000;
    use_lfsr = 1'b0;
    lfsr_q   = 16'h0001;
    step();
    step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_value", 32'(value_o), 32'd0);
    check("rst_rejcnt", 32'(reject_cnt_o), 32'd0);
    check("rst_strobe", 32'(lfsr_next_o), 32'd0);

    // Release reset: WARM lasts one cycle, then SAMPLE lasts one cycle.
    rst_i    = 1'b0;
    rand_drv = 16'h0035;
    check("warm_strobe", 32'(lfsr_next_o), 32'd0);
    step();
    check("sample_strobe", 32'(lfsr_next_o), 32'd1);
    check("sample_valid", 32'(valid_o), 32'd0);
    step();
    check("accept_value", 32'(value_o), 32'd53);
    check("accept_valid", 32'(valid_o), 32'd1);
    check("accept_rejcnt", 32'(reject_cnt_o), 32'd0);
    check("hold_strobe", 32'(lfsr_next_o), 32'd0);

    // Keep ready low: the result must be held with no strobes.
    rand_drv = 16'h0012;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_value", 32'(value_o), 32'd53);
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_strobe", 32'(lfsr_next_o), 32'd0);
    end

    // Transfer, then one reject followed by an accept.
    ready_i = 1'b1;
    step();
    ready_i  = 1'b0;
    rand_drv = 16'h00E4;
    check("xfer_valid", 32'(valid_o), 32'd0);
    check("xfer_strobe", 32'(lfsr_next_o), 32'd1);
    step();
    check("rej1_strobe", 32'(lfsr_next_o), 32'd1);
    check("rej1_valid", 32'(valid_o), 32'd0);
    check("rej1_rejcnt", 32'(reject_cnt_o), 32'd1);
    rand_drv = 16'h0010;
    step();
    check("rej1_value", 32'(value_o), 32'd16);
    check("rej1_valid2", 32'(valid_o), 32'd1);
    check("rej1_rejcnt2", 32'(reject_cnt_o), 32'd1);
    check("rej1_strobe2", 32'(lfsr_next_o), 32'd0);

    // Forced fold: four rejects of 127 produce 127-100 = 27.
    ready_i = 1'b1;
    step();
    ready_i  = 1'b0;
    rand_drv = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      check("fold_strobe", 32'(lfsr_next_o), 32'd1);
      check("fold_pending", 32'(valid_o), 32'd0);
      step();
    end
    check("fold_value", 32'(value_o), 32'd27);
    check("fold_valid", 32'(valid_o), 32'd1);
    check("fold_rejcnt", 32'(reject_cnt_o), 32'd5);
    check("fold_strobe_end", 32'(lfsr_next_o), 32'd0);

    // Continuous ready with accepting input: one result every two cycles.
    rand_drv = 16'h0035;
    ready_i  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("tog_valid", 32'(valid_o), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 1) check("tog_value", 32'(value_o), 32'd53);
    end
    ready_i = 1'b0;

    // Asynchronous reset while holding a result, applied between edges.
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_rejcnt", 32'(reject_cnt_o), 32'd0);
    check("arst_value", 32'(value_o), 32'd0);
    check("arst_strobe", 32'(lfsr_next_o), 32'd0);
    step();
    rst_i    = 1'b0;
    rand_drv = 16'h0047;
    check("rewarm_strobe", 32'(lfsr_next_o), 32'd0);
    step();
    check("resample_strobe", 32'(lfsr_next_o), 32'd1);
    step();
    check("reaccept_value", 32'(value_o), 32'd71);
    check("reaccept_valid", 32'(valid_o), 32'd1);

    // Real LFSR: 10000 transfers. All results must be in range, and every
    // value must appear.
    use_lfsr  = 1'b1;
    ready_i   = 1'b1;
    transfers = 0;
    cycles    = 0;
    while (transfers < 10000 && cycles < 60000) begin
      if (valid_o) begin
        check("lfsr_in_range", 32'(value_o < 8'd100), 32'd1);
        if (value_o < 8'd100) seen[value_o] = 1'b1;
        transfers++;
      end
      step();
      cycles++;
    end
    check("lfsr_transfers", 32'(transfers), 32'd10000);
    missing = 0;
    for (int v = 0; v < 100; v++) if (!seen[v]) missing++;
    check("lfsr_coverage_missing", 32'(missing), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
